// File: rtl/mem_responder_512x8_pkg.sv
// rtl/mem_responder_512x8_pkg.sv - op3 codes, FSM states and access decode for the byte-serial memory responder
package mem_responder_512x8_pkg;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic  legal;
        logic  is_load;
        logic  sign;
        size_t size;
    } op_info_t;

    // LDD/STD and every unlisted op3 come back with legal=0
    function automatic op_info_t decode_op(input logic [5:0] op3);
        op_info_t d;
        d = '{legal: 1'b1, is_load: 1'b1, sign: 1'b0, size: SZ_WORD};
        case (op3)
            OP_LD:   d.size = SZ_WORD;
            OP_LDUB: d.size = SZ_BYTE;
            OP_LDUH: d.size = SZ_HALF;
            OP_LDSB: begin d.size = SZ_BYTE; d.sign = 1'b1; end
            OP_LDSH: begin d.size = SZ_HALF; d.sign = 1'b1; end
            OP_ST:   begin d.size = SZ_WORD; d.is_load = 1'b0; end
            OP_STB:  begin d.size = SZ_BYTE; d.is_load = 1'b0; end
            OP_STH:  begin d.size = SZ_HALF; d.is_load = 1'b0; end
            default: begin d.legal = 1'b0; d.is_load = 1'b0; end
        endcase
        return d;
    endfunction

    // Index of the final byte moved for an access of this size
    function automatic logic [1:0] last_index(input size_t size);
        case (size)
            SZ_BYTE: return 2'd0;
            SZ_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input size_t size, input logic sign);
        case (size)
            SZ_BYTE: return {{24{sign & raw[7]}}, raw[7:0]};
            SZ_HALF: return {{16{sign & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_512x8_ram.sv
// rtl/mem_responder_512x8_ram.sv - byte array with synchronous write and asynchronous read, no reset
module ram_byte_array_512x8 #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    input  logic              we,
    output logic [7:0]        dout
);

    logic [7:0] mem [DEPTH];

    // Write port: one byte per enabled clock
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/mem_responder_512x8.sv
// rtl/mem_responder_512x8.sv - load/store responder: decode, wait states, byte-serial transfer, MFC handshake
module mem_responder_512x8
    import mem_responder_512x8_pkg::*;
#(
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        RAM_enable,
    input  logic [5:0]  RAM_OpCode,
    input  logic [31:0] MAR_In,
    input  logic [31:0] MDR_In,
    output logic [31:0] RAM_Out,
    output logic        MFC,
    output logic        MSET
);

    localparam int CNT_W = $clog2(WAIT_STATES + 2);

    state_t            state, state_nx;
    op_info_t          req_op;
    logic              req_err;
    logic              ld_q, sign_q, err_q;
    size_t             size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        idx_q;
    logic [31:0]       asm_q;
    logic [1:0]        sel;
    logic [31:0]       data_sh;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din, ram_dout;
    logic              ram_we;

    assign req_op  = decode_op(RAM_OpCode);
    assign req_err = !req_op.legal
                   || (req_op.size == SZ_HALF && MAR_In[0])
                   || (req_op.size == SZ_WORD && MAR_In[1:0] != 2'b00)
                   || (MAR_In >= 32'(DEPTH));

    // Byte idx_q is the idx_q-th byte from the MSB end of the low N bytes of the store data
    assign sel      = last_index(size_q) - idx_q;
    assign data_sh  = data_q >> {sel, 3'b000};
    assign ram_din  = data_sh[7:0];
    assign ram_addr = addr_q + ADDR_W'(idx_q);
    assign ram_we   = (state == ST_XFER) && !ld_q;

    ram_byte_array_512x8 #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk  (Clk),
        .addr (ram_addr),
        .din  (ram_din),
        .we   (ram_we),
        .dout (ram_dout)
    );

    // State register
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; DONE spends its first cycle raising MFC, then waits for the initiator to let go
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (RAM_enable) begin
                    if (req_err)               state_nx = ST_DONE;
                    else if (WAIT_STATES == 0) state_nx = ST_XFER;
                    else                       state_nx = ST_WAIT;
                end
            end
            ST_WAIT: if (cnt_q == CNT_W'(1)) state_nx = ST_XFER;
            ST_XFER: if (idx_q == last_index(size_q)) state_nx = ST_DONE;
            ST_DONE: if (MFC && !RAM_enable) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Request capture, wait counter, byte index, load assembly and registered handshake outputs
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            RAM_Out <= '0;
            MFC     <= 1'b0;
            MSET    <= 1'b0;
            ld_q    <= 1'b0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (RAM_enable) begin
                        ld_q   <= req_op.is_load;
                        sign_q <= req_op.sign;
                        size_q <= req_op.size;
                        err_q  <= req_err;
                        addr_q <= MAR_In[ADDR_W-1:0];
                        data_q <= MDR_In;
                        cnt_q  <= CNT_W'(WAIT_STATES);
                        idx_q  <= '0;
                        asm_q  <= '0;
                    end
                end
                ST_WAIT: cnt_q <= cnt_q - CNT_W'(1);
                ST_XFER: begin
                    idx_q <= idx_q + 2'd1;
                    if (ld_q) begin
                        asm_q <= {asm_q[23:0], ram_dout};
                    end
                end
                ST_DONE: begin
                    if (!MFC) begin
                        MFC  <= 1'b1;
                        MSET <= err_q;
                        if (!err_q && ld_q) begin
                            RAM_Out <= extend_load(asm_q, size_q, sign_q);
                        end
                    end else if (!RAM_enable) begin
                        MFC  <= 1'b0;
                        MSET <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
